// File: rtl/instr_fetch.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response FIFO, redirect/flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN: a misaligned redirect sets sticky fetch_fault and halts fetch.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);
  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW:0]   DEPTH_C  = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_N  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic          halted_q, halted_d;
  logic          fault_q, fault_d;
  logic [PW-1:0] fifo_rd_q, fifo_rd_d, fifo_wr_q, fifo_wr_d;
  logic [PW-1:0] tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   tag_pc_q    [DEPTH];

  logic accept, rsp, rsp_live, push, pop, misalign;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit covers both outstanding requests (stale included) and buffered entries.
  assign imem_req_valid = rst_n && !halted_q &&
                          (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_C);
  assign imem_addr   = pc_q;
  assign accept      = imem_req_valid && imem_req_ready;
  assign rsp         = imem_rsp_valid && (inflight_q != '0);
  assign rsp_live    = rsp && (drop_q == '0);
  assign push        = rsp_live && !redirect_valid;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign instr       = instr_valid ? fifo_data_q[fifo_rd_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[fifo_rd_q] : '0;
  assign fetch_fault = fault_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    count_d    = count_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    halted_d   = halted_q;
    fault_d    = fault_q;

    if (accept) pc_d = pc_q + 32'd4;
    if (accept && !rsp) inflight_d = inflight_q + CW'(1);
    else if (!accept && rsp) inflight_d = inflight_q - CW'(1);
    if (rsp && !rsp_live) drop_d = drop_q - CW'(1);

    if (redirect_valid) begin
      // Everything still outstanding after this edge, including this cycle's accept, is stale.
      pc_d      = redirect_pc & 32'hFFFF_FFFC;
      drop_d    = inflight_d;
      count_d   = '0;
      fifo_rd_d = '0;
      fifo_wr_d = '0;
      tag_rd_d  = '0;
      tag_wr_d  = '0;
      if (misalign) begin
        halted_d = 1'b1;
        fault_d  = 1'b1;
      end
    end else begin
      if (accept) tag_wr_d = ptr_inc(tag_wr_q);
      if (push) begin
        tag_rd_d  = ptr_inc(tag_rd_q);
        fifo_wr_d = ptr_inc(fifo_wr_q);
      end
      if (pop) fifo_rd_d = ptr_inc(fifo_rd_q);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  // Storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept && !redirect_valid) tag_pc_q[tag_wr_q] <= pc_q;
    if (push) begin
      fifo_pc_q[fifo_wr_q]   <= tag_pc_q[tag_rd_q];
      fifo_data_q[fifo_wr_q] <= imem_rsp_data;
    end
  end

  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count_q == DEPTH_N)));

endmodule
